// File: rtl/i2s_transmitter.sv
// I2S master transmitter: stereo samples in through a single-entry
// valid/ready holding register, serialised MSB-first in standard I2S
// framing (data one BCLK after the LRCLK edge, 32 BCLK slots per channel).
module i2s_transmitter #(
    parameter int BCLK_DIV = 12,
    parameter int WIDTH    = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] left_sample_in,
    input  logic signed [WIDTH-1:0] right_sample_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic                    i2s_bclk_out,
    output logic                    i2s_lrclk_out,
    output logic                    i2s_data_out,
    output logic                    frame_start_out,
    output logic                    underrun_out
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic                    bclk_q, bclk_d;
    logic                    lrclk_q, lrclk_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic                    data_q, data_d;
    logic                    ready_q, ready_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;
    logic [63:0]             shift_q, shift_d;
    logic signed [WIDTH-1:0] hold_left_q, hold_left_d;
    logic signed [WIDTH-1:0] hold_right_q, hold_right_d;
    logic                    div_last;
    logic                    fall_evt;

    // Lay a sample pair out as a 64-slot frame; bit 63 is slot 0, so the
    // left MSB sits in slot 1 and the right MSB in slot 33.
    function automatic logic [63:0] build_frame(input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] r);
        logic [63:0] f;
        f          = '0;
        f[62 -: WIDTH] = l;
        f[30 -: WIDTH] = r;
        return f;
    endfunction

    // Next-state: divider, falling-edge sequencing, frame load and handshake.
    always_comb begin
        div_last      = (div_cnt_q == DIV_LAST);
        fall_evt      = div_last && bclk_q;
        div_cnt_d     = div_last ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d        = div_last ? ~bclk_q : bclk_q;
        lrclk_d       = lrclk_q;
        bit_cnt_d     = bit_cnt_q;
        data_d        = data_q;
        ready_d       = ready_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        shift_d       = shift_q;
        hold_left_d   = hold_left_q;
        hold_right_d  = hold_right_q;

        if (fall_evt) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrclk_d   = bit_cnt_d[5];
            if (bit_cnt_d == 6'd0) begin
                // Slot 0 is the trailing zero of the previous right slot;
                // the loaded frame starts shifting from slot 1 onwards.
                frame_start_d = 1'b1;
                data_d        = 1'b0;
                if (!ready_q) begin
                    shift_d = build_frame(hold_left_q, hold_right_q) << 1;
                    ready_d = 1'b1;
                end else begin
                    shift_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                data_d  = shift_q[63];
                shift_d = {shift_q[62:0], 1'b0};
            end
        end

        // ready_q is low whenever the register is full, so this never
        // collides with a load of held data.
        if (valid_in && ready_q) begin
            hold_left_d  = left_sample_in;
            hold_right_d = right_sample_in;
            ready_d      = 1'b0;
        end
    end

    // Control and output state; reset aborts any frame and empties the holder.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b1;
            bit_cnt_q     <= 6'd63;
            data_q        <= 1'b0;
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            shift_q       <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            bit_cnt_q     <= bit_cnt_d;
            data_q        <= data_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            shift_q       <= shift_d;
        end
    end

    // Holding data is qualified by ready_q, so it needs no reset.
    always_ff @(posedge clk_in) begin
        hold_left_q  <= hold_left_d;
        hold_right_q <= hold_right_d;
    end

    assign ready_out       = ready_q;
    assign i2s_bclk_out    = bclk_q;
    assign i2s_lrclk_out   = lrclk_q;
    assign i2s_data_out    = data_q;
    assign frame_start_out = frame_start_q;
    assign underrun_out    = underrun_q;

endmodule
